fp_div_seq: RTL and testbench

- Iterative IEEE-754 single-precision divider: result = a_operand / b_operand. It is the inverse-operation companion to the ALU's combinational multiplier.
- One restoring-division step per clock, with start/busy/done handshake.
- Produces result plus Exception/Overflow/Underflow flags, with the same flag meanings and flush-to-zero policy as the multiplier.
- Sits in the ALU beside the multiplier; the ALU result mux samples it on done.

---
 rtl/fp_div_seq.sv | 155 +++++++++++++++
 tb/tb_fp_div_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_seq.sv
// Iterative IEEE-754 single-precision divider: one restoring-division step per clock,
// then a round/normalise cycle that writes result and flags and pulses done.
module fp_div_seq #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23,
  parameter int BIAS   = 127,
  parameter int ITER   = MANT_W + 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        Exception,
  output logic        Overflow,
  output logic        Underflow
);

  localparam int W    = 1 + EXP_W + MANT_W;
  localparam int MW   = MANT_W + 1;
  localparam int EW2  = EXP_W + 2;
  localparam int CW   = $clog2(ITER);
  localparam int EMAX = (1 << EXP_W) - 1;

  // Handshake: start is accepted only in IDLE and not in the done cycle; busy is high
  // from the cycle after acceptance until done; done is a one-cycle pulse and the
  // result/flags it qualifies hold until the next done or reset.
  typedef enum logic [1:0] {IDLE, DIV, RND} state_t;

  state_t             state, state_n;
  logic               accept;
  logic               sign;
  logic [EXP_W-1:0]   ea, eb;
  logic [MW-1:0]      mb;
  logic [MW:0]        rem;
  logic [ITER-1:0]    q;
  logic [CW-1:0]      cnt;
  logic [MW+1:0]      trial;

  logic [MANT_W-1:0]  mant;
  logic               guard, sticky, round_up, exc_n, ovf_n, unf_n;
  logic [MANT_W:0]    mant_rnd;
  logic [EW2-1:0]     ebias_pre, ebias_fin;
  logic [W-1:0]       res_n;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start && !done) state_n = DIV;
      DIV:     if (cnt == '0)      state_n = RND;
      RND:                         state_n = IDLE;
      default:                     state_n = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy   = (state != IDLE);
    accept = (state == IDLE) && start && !done;
  end

  assign trial = {1'b0, rem} - {2'b00, mb};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign <= 1'b0;
      ea   <= '0;
      eb   <= '0;
      mb   <= '0;
      rem  <= '0;
      q    <= '0;
      cnt  <= '0;
    end else if (accept) begin
      sign <= a_operand[W-1] ^ b_operand[W-1];
      ea   <= a_operand[W-2:MANT_W];
      eb   <= b_operand[W-2:MANT_W];
      mb   <= {|b_operand[W-2:MANT_W], b_operand[MANT_W-1:0]};
      rem  <= {1'b0, |a_operand[W-2:MANT_W], a_operand[MANT_W-1:0]};
      q    <= '0;
      cnt  <= CW'(ITER - 1);
    end else if (state == DIV) begin
      // The remainder stays below 2*Mb, so a non-negative trial fits in MW bits.
      if (!trial[MW+1]) begin
        q   <= {q[ITER-2:0], 1'b1};
        rem <= {trial[MW-1:0], 1'b0};
      end else begin
        q   <= {q[ITER-2:0], 1'b0};
        rem <= {rem[MW-1:0], 1'b0};
      end
      cnt <= cnt - CW'(1);
    end
  end

  // Normalise, round to nearest even, then apply overrides in priority order.
  always_comb begin
    if (q[ITER-1]) begin
      mant   = q[ITER-2:2];
      guard  = q[1];
      sticky = q[0] | (|rem);
    end else begin
      mant   = q[ITER-3:1];
      guard  = q[0];
      sticky = |rem;
    end
    ebias_pre = {2'b00, ea} - {2'b00, eb} + EW2'(BIAS) - {{(EW2-1){1'b0}}, ~q[ITER-1]};
    round_up  = guard & (sticky | mant[0]);
    mant_rnd  = {1'b0, mant} + {{MANT_W{1'b0}}, round_up};
    ebias_fin = ebias_pre + {{(EW2-1){1'b0}}, mant_rnd[MANT_W]};

    exc_n = (ea == EXP_W'(EMAX)) || (eb == EXP_W'(EMAX)) || (eb == '0);
    ovf_n = 1'b0;
    unf_n = 1'b0;
    res_n = {sign, ebias_fin[EXP_W-1:0], mant_rnd[MANT_W-1:0]};
    if (exc_n) begin
      res_n = '0;
    end else if (ea == '0) begin
      res_n = {sign, {(W-1){1'b0}}};
    end else if (!ebias_fin[EW2-1] && (ebias_fin[EW2-2:0] >= (EW2-1)'(EMAX))) begin
      ovf_n = 1'b1;
      res_n = {sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    end else if (ebias_fin[EW2-1] || (ebias_fin == '0)) begin
      unf_n = 1'b1;
      res_n = {sign, {(W-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      result    <= '0;
      Exception <= 1'b0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      done <= (state == RND);
      if (state == RND) begin
        result    <= res_n;
        Exception <= exc_n;
        Overflow  <= ovf_n;
        Underflow <= unf_n;
      end
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Bench for fp_div_seq: directed cases with known quotients plus random operands
// checked against an integer-division reference model.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a_operand = '0;
  logic [31:0] b_operand = '0;
  logic        busy, done, Exception, Overflow, Underflow;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  logic [34:0] exp_q[$];

  fp_div_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_operand(a_operand), .b_operand(b_operand),
    .busy(busy), .done(done), .result(result),
    .Exception(Exception), .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {Exception, Overflow, Underflow, result} from exact integer division.
  function automatic logic [34:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    int unsigned ea = a[30:23];
    int unsigned eb = b[30:23];
    logic        s  = a[31] ^ b[31];
    longint      ma, mb, num, qt, rm, mant, e;
    logic        g, st;
    if (ea == 255 || eb == 255 || eb == 0) return {3'b100, 32'h0};
    if (ea == 0) return {3'b000, s, 31'h0};
    ma  = 64'h800000 | longint'(a[22:0]);
    mb  = 64'h800000 | longint'(b[22:0]);
    num = ma << 25;
    qt  = num / mb;
    rm  = num % mb;
    e   = longint'(ea) - longint'(eb) + 127;
    if (qt >= (64'd1 << 25)) begin
      mant = (qt >> 2) & 64'h7FFFFF;
      g    = qt[1];
      st   = qt[0] || (rm != 0);
    end else begin
      mant = (qt >> 1) & 64'h7FFFFF;
      g    = qt[0];
      st   = (rm != 0);
      e    = e - 1;
    end
    if (g && (st || mant[0])) begin
      mant = mant + 1;
      if (mant == (64'd1 << 23)) begin
        mant = 0;
        e    = e + 1;
      end
    end
    if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
    if (e <= 0)   return {3'b001, s, 31'h0};
    return {3'b000, s, e[7:0], mant[22:0]};
  endfunction

  // Called at #1 after a posedge with the DUT idle; returns just after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [34:0] exp);
    a_operand = a;
    b_operand = b;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    exp_q.push_back(exp);
  endtask

  // Waits (bounded) for done; cyc0 is the number of edges already elapsed since acceptance.
  task automatic wait_done(input string tag, input int cyc0);
    int cyc = cyc0;
    logic [34:0] exp;
    while (!done && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    exp = exp_q.pop_front();
    if (!done) begin
      check({tag, " timeout"}, 64'(done), 64'(1));
      return;
    end
    check({tag, " latency"}, 64'(cyc), 64'(27));
    check({tag, " result"}, 64'({Exception, Overflow, Underflow, result}), 64'(exp));
  endtask

  task automatic done_width(input string tag);
    @(posedge clk); #1;
    check({tag, " done width"}, 64'(done), 64'(0));
  endtask

  function automatic logic [31:0] rand_op();
    logic [7:0] e;
    int unsigned sel = $urandom_range(0, 19);
    if (sel == 0)      e = 8'h00;
    else if (sel == 1) e = 8'hFF;
    else if (sel < 5)  e = 8'($urandom_range(1, 254));
    else               e = 8'($urandom_range(100, 154));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  initial begin
    int seen;
    logic [31:0] ra, rb;
    #1;
    check("reset state", 64'({busy, done, Exception, Overflow, Underflow, result}), 64'(0));
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    issue(32'h40C00000, 32'h40000000, {3'b000, 32'h40400000});
    wait_done("6/2", 0);
    check("6/2 busy at done", 64'(busy), 64'(0));
    done_width("6/2");

    issue(32'h3F800000, 32'h40400000, {3'b000, 32'h3EAAAAAB});
    wait_done("1/3", 0);
    done_width("1/3");

    issue(32'hC0C00000, 32'h40000000, {3'b000, 32'hC0400000});
    wait_done("-6/2", 0);
    done_width("-6/2");

    issue(32'h3F800000, 32'h00000000, {3'b100, 32'h0});
    wait_done("div by zero", 0);
    done_width("div by zero");

    issue(32'h7F800000, 32'h3F800000, {3'b100, 32'h0});
    wait_done("inf dividend", 0);
    done_width("inf dividend");

    issue(32'h7F000000, 32'h3F000000, {3'b010, 32'h7F800000});
    wait_done("overflow", 0);
    done_width("overflow");

    issue(32'h00800000, 32'h40000000, {3'b001, 32'h00000000});
    wait_done("underflow", 0);
    done_width("underflow");

    // Second start while busy must be ignored.
    issue(32'h40C00000, 32'h40000000, {3'b000, 32'h40400000});
    repeat (9) begin @(posedge clk); #1; end
    a_operand = 32'h3F800000;
    b_operand = 32'h40400000;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    wait_done("start while busy", 10);

    // Start held through the done cycle: ignored on that edge, accepted on the next.
    a_operand = 32'h41200000;
    b_operand = 32'h40800000;
    start     = 1'b1;
    @(posedge clk); #1;
    check("start in done cycle ignored", 64'({busy, done}), 64'(0));
    @(posedge clk); #1;
    start = 1'b0;
    check("start after done accepted", 64'(busy), 64'(1));
    exp_q.push_back({3'b000, 32'h40200000});
    wait_done("back to back", 0);
    done_width("back to back");

    // Reset in the middle of a division.
    issue(32'h3F800000, 32'h40400000, {3'b000, 32'h3EAAAAAB});
    repeat (11) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("mid reset outputs", 64'({busy, done, Exception, Overflow, Underflow, result}), 64'(0));
    void'(exp_q.pop_back());
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    check("no done after reset", 64'(seen), 64'(0));
    issue(32'h40C00000, 32'h40000000, {3'b000, 32'h40400000});
    wait_done("after reset", 0);
    done_width("after reset");

    for (int i = 0; i < 150; i++) begin
      ra = rand_op();
      rb = rand_op();
      issue(ra, rb, ref_div(ra, rb));
      wait_done($sformatf("rand%0d %h/%h", i, ra, rb), 0);
      done_width("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
